// File: rtl/watch_time_sender.sv
// Formats a snapshot of hour/min/sec as "HH:MM:SS\r\n" and writes it byte-by-byte to the UART TX FIFO.
// Optional macro CENTI_FIELD_EN appends ".CC" (centiseconds) after the seconds field.
module watch_time_sender (
  input  logic       clk,
  input  logic       reset,
  input  logic       send,
  input  logic [4:0] hour,
  input  logic [5:0] min,
  input  logic [5:0] sec,
  input  logic [6:0] centi,
  input  logic       fifo_full,
  output logic       fifo_wr_en,
  output logic [7:0] fifo_tx_data,
  output logic       busy
);

`ifdef CENTI_FIELD_EN
  localparam int unsigned FRAME_LEN = 13;
`else
  localparam int unsigned FRAME_LEN = 10;
`endif
  localparam logic [3:0] LAST_IDX = 4'(FRAME_LEN - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EMIT = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  // Values of 100 or more wrap modulo 100 before splitting into digits.
  function automatic logic [6:0] mod100(input logic [6:0] v);
    return (v >= 7'd100) ? (v - 7'd100) : v;
  endfunction

  function automatic logic [7:0] tens_ascii(input logic [6:0] v);
    logic [6:0] m;
    m = mod100(v);
    return 8'h30 + {4'd0, 4'(m / 7'd10)};
  endfunction

  function automatic logic [7:0] ones_ascii(input logic [6:0] v);
    logic [6:0] m;
    m = mod100(v);
    return 8'h30 + {4'd0, 4'(m % 7'd10)};
  endfunction

  state_t     r_state;
  logic [3:0] r_idx;
  logic [4:0] r_hour;
  logic [5:0] r_min;
  logic [5:0] r_sec;
  logic       r_wr_en;
  logic [7:0] r_tx_data;
  logic       r_busy;
  logic [7:0] w_byte;

`ifdef CENTI_FIELD_EN
  logic [6:0] r_centi;
`else
  logic       w_centi_unused;
  assign w_centi_unused = ^centi;
`endif

  always_comb begin
    w_byte = 8'h00;
    case (r_idx)
      4'd0:    w_byte = tens_ascii({2'b00, r_hour});
      4'd1:    w_byte = ones_ascii({2'b00, r_hour});
      4'd2:    w_byte = 8'h3A;
      4'd3:    w_byte = tens_ascii({1'b0, r_min});
      4'd4:    w_byte = ones_ascii({1'b0, r_min});
      4'd5:    w_byte = 8'h3A;
      4'd6:    w_byte = tens_ascii({1'b0, r_sec});
      4'd7:    w_byte = ones_ascii({1'b0, r_sec});
`ifdef CENTI_FIELD_EN
      4'd8:    w_byte = 8'h2E;
      4'd9:    w_byte = tens_ascii(r_centi);
      4'd10:   w_byte = ones_ascii(r_centi);
      4'd11:   w_byte = 8'h0D;
      4'd12:   w_byte = 8'h0A;
`else
      4'd8:    w_byte = 8'h0D;
      4'd9:    w_byte = 8'h0A;
`endif
      default: w_byte = 8'h00;
    endcase
  end

  // GAP after every write gives fifo_full a cycle to reflect the new entry.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_idx     <= 4'd0;
      r_hour    <= 5'd0;
      r_min     <= 6'd0;
      r_sec     <= 6'd0;
`ifdef CENTI_FIELD_EN
      r_centi   <= 7'd0;
`endif
      r_wr_en   <= 1'b0;
      r_tx_data <= 8'h00;
      r_busy    <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_wr_en <= 1'b0;
          if (send) begin
            r_hour  <= hour;
            r_min   <= min;
            r_sec   <= sec;
`ifdef CENTI_FIELD_EN
            r_centi <= centi;
`endif
            r_idx   <= 4'd0;
            r_busy  <= 1'b1;
            r_state <= ST_EMIT;
          end
        end
        ST_EMIT: begin
          if (!fifo_full) begin
            r_wr_en   <= 1'b1;
            r_tx_data <= w_byte;
            r_state   <= ST_GAP;
          end else begin
            r_wr_en   <= 1'b0;
          end
        end
        ST_GAP: begin
          r_wr_en <= 1'b0;
          if (r_idx == LAST_IDX) begin
            r_idx   <= 4'd0;
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end else begin
            r_idx   <= r_idx + 4'd1;
            r_state <= ST_EMIT;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_idx   <= 4'd0;
          r_wr_en <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign fifo_wr_en   = r_wr_en;
  assign fifo_tx_data = r_tx_data;
  assign busy         = r_busy;

endmodule

// File: tb/tb_watch_time_sender.sv
// Self-checking bench for watch_time_sender: table-driven frames plus backpressure, snapshot and reset sequences.
module tb_watch_time_sender;

`ifdef CENTI_FIELD_EN
  localparam int FRAME_LEN = 13;
`else
  localparam int FRAME_LEN = 10;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       send = 1'b0;
  logic [4:0] hour = 5'd0;
  logic [5:0] min = 6'd0;
  logic [5:0] sec = 6'd0;
  logic [6:0] centi = 7'd0;
  logic       fifo_full = 1'b0;
  logic       fifo_wr_en;
  logic [7:0] fifo_tx_data;
  logic       busy;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];

  typedef struct {
    logic [4:0]  h;
    logic [5:0]  m;
    logic [5:0]  s;
    logic [6:0]  c;
    logic [79:0] e;
  } vec_t;
  vec_t vecs[5];

  watch_time_sender dut (
    .clk(clk), .reset(reset), .send(send), .hour(hour), .min(min), .sec(sec),
    .centi(centi), .fifo_full(fifo_full), .fifo_wr_en(fifo_wr_en),
    .fifo_tx_data(fifo_tx_data), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic check_byte();
    logic [7:0] e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL byte: unexpected write 0x%02h with empty scoreboard", fifo_tx_data);
    end else begin
      e = exp_q.pop_front();
      if (fifo_tx_data !== e) begin
        errors++;
        $display("FAIL byte: got 0x%02h expected 0x%02h", fifo_tx_data, e);
      end
    end
  endtask

  // Drives the time inputs and pushes the expected frame into the scoreboard.
  task automatic push_frame(input vec_t v);
    int cc;
    hour = v.h; min = v.m; sec = v.s; centi = v.c;
    for (int i = 0; i < 8; i++) exp_q.push_back(v.e[79-8*i -: 8]);
`ifdef CENTI_FIELD_EN
    cc = int'(v.c) % 100;
    exp_q.push_back(8'h2E);
    exp_q.push_back(8'(48 + cc / 10));
    exp_q.push_back(8'(48 + cc % 10));
`else
    cc = 0;
`endif
    exp_q.push_back(v.e[15:8]);
    exp_q.push_back(v.e[7:0]);
  endtask

  // t counts negedges after the send edge; inputs set at negedge t reach edge t+1.
  task automatic run_frame(input int ff_from, input int ff_len, input int mid_t,
                           input logic [5:0] mid_sec, output int busy_cyc,
                           output int strobes, output int first_t, output int third_t);
    int t;
    logic prev_wr;
    busy_cyc = 0; strobes = 0; first_t = -1; third_t = -1; prev_wr = 1'b0;
    @(negedge clk) send = 1'b1;
    @(negedge clk) send = 1'b0;
    t = 0;
    while (t < 200) begin
      if (fifo_wr_en) begin
        strobes++;
        if (strobes == 1) first_t = t;
        if (strobes == 3) third_t = t;
        check_byte();
        if (prev_wr) check("strobe_gap", 1, 0);
      end
      prev_wr = fifo_wr_en;
      if (!busy) break;
      busy_cyc++;
      fifo_full = (t >= ff_from && t < ff_from + ff_len);
      if (t == mid_t) begin
        sec = mid_sec;
        send = 1'b1;
      end else begin
        send = 1'b0;
      end
      @(negedge clk);
      t++;
    end
    if (t >= 200) check("frame_timeout", t, 0);
    fifo_full = 1'b0;
    send = 1'b0;
  endtask

  initial begin
    int bc, st, ft, tt, n;
    vecs[0] = '{5'd12, 6'd34, 6'd56, 7'd7,   80'h3132_3A33_343A_3536_0D0A};
    vecs[1] = '{5'd0,  6'd63, 6'd9,  7'd0,   80'h3030_3A36_333A_3039_0D0A};
    vecs[2] = '{5'd31, 6'd0,  6'd59, 7'd99,  80'h3331_3A30_303A_3539_0D0A};
    vecs[3] = '{5'd7,  6'd45, 6'd0,  7'd127, 80'h3037_3A34_353A_3030_0D0A};
    vecs[4] = '{5'd1,  6'd2,  6'd3,  7'd7,   80'h3031_3A30_323A_3033_0D0A};

    repeat (3) @(negedge clk);
    check("rst_wr_en", int'(fifo_wr_en), 0);
    check("rst_tx_data", int'(fifo_tx_data), 0);
    check("rst_busy", int'(busy), 0);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check("idle_busy", int'(busy), 0);

    for (int i = 0; i < 5; i++) begin
      push_frame(vecs[i]);
      run_frame(-1, 0, -1, 6'd0, bc, st, ft, tt);
      check("vec_strobes", st, FRAME_LEN);
      check("vec_busy_cycles", bc, 2 * FRAME_LEN);
      check("vec_first_strobe_t", ft, 1);
      check("vec_sb_empty", exp_q.size(), 0);
      @(negedge clk);
    end

    // Backpressure on the third byte for 5 cycles
    push_frame(vecs[0]);
    run_frame(4, 5, -1, 6'd0, bc, st, ft, tt);
    check("bp_strobes", st, FRAME_LEN);
    check("bp_busy_cycles", bc, 2 * FRAME_LEN + 5);
    check("bp_third_t", tt, 10);
    check("bp_sb_empty", exp_q.size(), 0);

    // Snapshot: sec changes and send repeats mid-frame
    push_frame(vecs[0]);
    run_frame(-1, 0, 6, 6'd57, bc, st, ft, tt);
    check("snap_strobes", st, FRAME_LEN);
    check("snap_busy_cycles", bc, 2 * FRAME_LEN);
    check("snap_sb_empty", exp_q.size(), 0);
    repeat (3) begin
      @(negedge clk);
      check("snap_no_requeue_wr", int'(fifo_wr_en), 0);
      check("snap_no_requeue_busy", int'(busy), 0);
    end
    push_frame('{5'd12, 6'd34, 6'd57, 7'd7, 80'h3132_3A33_343A_3537_0D0A});
    run_frame(-1, 0, -1, 6'd0, bc, st, ft, tt);
    check("snap2_strobes", st, FRAME_LEN);
    check("snap2_sb_empty", exp_q.size(), 0);

    // Reset asserted right after the 4th strobe
    push_frame(vecs[1]);
    @(negedge clk) send = 1'b1;
    @(negedge clk) send = 1'b0;
    st = 0; n = 0;
    while (st < 4 && n < 40) begin
      if (fifo_wr_en) begin
        st++;
        check_byte();
      end
      if (st < 4) begin
        @(negedge clk);
        n++;
      end
    end
    check("rstmid_reached_4", st, 4);
    #1 reset = 1'b1;
    #1;
    check("rstmid_wr_en", int'(fifo_wr_en), 0);
    check("rstmid_busy", int'(busy), 0);
    check("rstmid_tx_data", int'(fifo_tx_data), 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    exp_q.delete();
    st = 0;
    repeat (6) begin
      @(negedge clk);
      if (fifo_wr_en || busy) st++;
    end
    check("rstmid_quiet", st, 0);
    push_frame(vecs[2]);
    run_frame(-1, 0, -1, 6'd0, bc, st, ft, tt);
    check("rstmid_new_strobes", st, FRAME_LEN);
    check("rstmid_new_busy", bc, 2 * FRAME_LEN);
    check("rstmid_sb_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/watch_time_sender.md
# watch_time_sender

Formats the current watch/stopwatch time as an ASCII line and pushes it byte-by-byte into the UART TX FIFO. It is the transmit-side counterpart of the RX command decoder. It sits between the time counters and the TX FIFO write port. One request produces one complete, self-consistent line, "HH:MM:SS\r\n", captured from a single-cycle snapshot of the time inputs.

## Interface
Parameters:
- none (frame length is set only by the configuration macro)

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- send  input  1  request pulse; sampled only in IDLE
- hour  input  5  hour value, 0–31
- min  input  6  minute value, 0–63
- sec  input  6  second value, 0–63
- centi  input  7  centisecond value, 0–127; used only with `CENTI_FIELD_EN`
- fifo_full  input  1  TX FIFO full flag
- fifo_wr_en  output  1  one-cycle write strobe, registered
- fifo_tx_data  output  8  byte to write, registered, valid while fifo_wr_en=1
- busy  output  1  high while a frame is in progress (state != IDLE)

## Operation
- Reset values: fifo_wr_en=0, fifo_tx_data=8'h00, busy=0, state=IDLE, byte index=0.
- States: IDLE, EMIT, GAP.
- IDLE, send=1:
  - snapshot hour/min/sec/centi into internal registers
  - index<=0
  - go to EMIT
- IDLE, send=0: no action.
- EMIT:
  - fifo_full=0: fifo_wr_en<=1, fifo_tx_data<=byte[index], go to GAP.
  - fifo_full=1: remain in EMIT, fifo_wr_en stays 0; no byte is dropped or skipped.
- GAP:
  - fifo_wr_en<=0
  - last byte: go to IDLE, index<=0
  - otherwise: index<=index+1, go to EMIT
  - The GAP cycle lets fifo_full settle after each write.
- Frame bytes, in order: tens(hour), ones(hour), 8'h3A, tens(min), ones(min), 8'h3A, tens(sec), ones(sec), 8'h0D, 8'h0A.
- Digit encoding: tens = (v mod 100)/10, ones = v mod 10; each digit is emitted as 8'h30 + digit. Values ≥100 wrap modulo 100.
- send while busy=1: ignored, not queued.
- Time inputs changing mid-frame: no effect; only the snapshot is emitted.
- Reset mid-frame: frame aborted immediately, outputs return to reset values, and no further bytes are written.

## Timing
- send=1 sampled at edge N: snapshot taken at N, busy=1 after N.
- With no backpressure:
  - byte k has fifo_wr_en=1 for the cycle following edge N+1+2k
  - every byte is 2 cycles, so fifo_wr_en is never high on consecutive cycles
  - 10-byte frame: last strobe after edge N+19, busy=0 after edge N+20
- Each cycle fifo_full=1 is sampled in EMIT adds one cycle of delay.
- Earliest next accepted send is at edge N+21 (first IDLE cycle).
- fifo_tx_data holds the last written byte until the next write.

## Configuration
- `CENTI_FIELD_EN` defined:
  - frame becomes "HH:MM:SS.CC\r\n", 13 bytes
  - 8'h2E, tens(centi), ones(centi) are inserted after ones(sec)
  - centi is snapshotted with the other fields
  - no backpressure: busy=0 after edge N+26
- `CENTI_FIELD_EN` undefined:
  - 10-byte frame
  - centi input is ignored and left unconnected internally

## Test plan
- Basic frame: hour=12, min=34, sec=56, fifo_full=0, single send → writes 31 32 3A 33 34 3A 35 36 0D 0A, each strobe 1 cycle wide with 1 idle cycle between, busy high for exactly 20 cycles.
- Backpressure: hold fifo_full=1 for 5 cycles while the 3rd byte is pending → 3rd byte (8'h3A) is written once fifo_full drops, no byte lost or duplicated, frame delayed by exactly 5 cycles.
- Snapshot and busy: change sec 56→57 and pulse send again mid-frame → output still contains 35 36, only one frame is written, and a send after busy falls emits 35 37.
- Boundary values: hour=0, min=63, sec=9 → 30 30 3A 36 33 3A 30 39 0D 0A.
- Reset mid-frame: assert reset after the 4th strobe → fifo_wr_en=0 and busy=0 immediately, no further strobes; a new send then emits a complete 10-byte frame.
- With `CENTI_FIELD_EN`: hour=1, min=2, sec=3, centi=7 → 30 31 3A 30 32 3A 30 33 2E 30 37 0D 0A, busy high for 26 cycles.
